fetch_queue: RTL and testbench

- Instruction fetch front end: owns the program counter and sits directly upstream of decode.
- Drives the instruction-memory address combinationally from the PC and captures {pc, instruction} pairs into a small FIFO.
- Presents the FIFO head to decode through a valid/ready handshake.
- A taken branch redirects fetch to a new PC and flushes all queued, now-wrong-path entries.

---
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, fetches from a combinational
// instruction memory and queues {pc, instr} pairs for decode.
module fetch_queue #(
  parameter int N = 64,
  parameter int DEPTH = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [N-1:0]             imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     imem_en,
  input  logic                     redirect,
  input  logic [N-1:0]             redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]  pc;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [N-1:0]  q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];

  logic full;
  logic pop;
  logic push;
  logic unused_redirect_lsbs;

  // Decode handshake: the head transfers on a rising edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready, and the
  // head stays stable until it transfers or a redirect/reset flushes it.
  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A full queue may still fetch when the head leaves in the same cycle.
  assign push      = reset & ~redirect & (~full | pop);

  assign imem_en   = push;
  assign imem_addr = pc;
  assign occupancy = count;
  assign out_pc    = out_valid ? q_pc[head]    : '0;
  assign out_instr = out_valid ? q_instr[head] : '0;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (redirect) begin
      // Flush wins over any concurrent push or pop.
      pc    <= {redirect_pc[N-1:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_pc[tail]    <= pc;
        q_instr[tail] <= imem_rdata;
        tail          <= tail + AW'(1);
        pc            <= pc + N'(4);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: reference model feeds an expected
// queue, a scoreboard checks every decode transfer, scenario tasks check the rest.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int N = 64;
  localparam int W = N + 32;
  localparam logic [31:0] K = 32'hD503201F;

  logic          clk;
  logic          reset;
  logic [N-1:0]  imem_addr;
  logic [31:0]   imem_rdata;
  logic          imem_en;
  logic          redirect;
  logic [N-1:0]  redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_pc;
  logic [31:0]   out_instr;
  logic [2:0]    occupancy;

  logic [N-1:0]  imem_addr_w;
  logic [31:0]   imem_rdata_w;
  logic          imem_en_w;
  logic          out_valid_w;
  logic [N-1:0]  out_pc_w;
  logic [31:0]   out_instr_w;
  logic [2:0]    occupancy_w;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];
  logic [N-1:0] m_pc;
  int           m_cnt;

  fetch_queue #(.N(N), .DEPTH(4), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_en(imem_en), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .occupancy(occupancy)
  );

  fetch_queue #(.N(N), .DEPTH(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .imem_en(imem_en_w), .redirect(1'b0), .redirect_pc(64'h0),
    .out_valid(out_valid_w), .out_ready(1'b1), .out_pc(out_pc_w),
    .out_instr(out_instr_w), .occupancy(occupancy_w)
  );

  // Combinational instruction memory model.
  assign imem_rdata   = imem_addr[31:0] ^ K;
  assign imem_rdata_w = imem_addr_w[31:0] ^ K;

  // Clock / reset block.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    m_pc = '0;
  endtask

  // Driver: applies one cycle of inputs at the falling edge and advances the
  // reference model for the rising edge that follows.
  task automatic cycle(input logic rdy, input logic rd, input logic [N-1:0] rpc);
    logic pop_m;
    logic push_m;
    @(negedge clk);
    reset = 1'b1;
    out_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
    if (rd) begin
      exp_q.delete();
      m_cnt = 0;
      m_pc = {rpc[N-1:2], 2'b00};
    end else begin
      pop_m = (m_cnt != 0) && rdy;
      push_m = (m_cnt < 4) || pop_m;
      if (push_m) begin
        exp_q.push_back({m_pc, m_pc[31:0] ^ K});
        m_pc = m_pc + 64'd4;
      end
      m_cnt = m_cnt + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
    end
  endtask

  // Scoreboard: every transfer to decode must match the oldest expected entry.
  always @(negedge clk) begin
    logic [W-1:0] e;
    #2;
    if (reset && !redirect && out_valid && out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_underflow: got pc %h with no entry expected", out_pc);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          tests_failed++;
          $display("FAIL sb_entry: got %h/%h expected %h/%h", out_pc, out_instr, e[W-1:32], e[31:0]);
        end
      end
    end
  end

  task automatic test_reset();
    do_reset();
    out_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    #1;
    tests_run++;
    if ({out_valid, imem_en, occupancy} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got v=%b en=%b occ=%0d expected 0/0/0", out_valid, imem_en, occupancy);
    end
    tests_run++;
    if ({out_pc, out_instr} !== 96'h0 || imem_addr !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got pc=%h instr=%h addr=%h expected zeros", out_pc, out_instr, imem_addr);
    end
  endtask

  task automatic test_stream();
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, '0);
      #3;
      tests_run++;
      if (out_pc !== 64'(4 * i) || out_instr !== (32'(4 * i) ^ K) || occupancy !== 3'd1) begin
        tests_failed++;
        $display("FAIL stream_%0d: got pc=%h instr=%h occ=%0d expected pc=%h occ=1",
                 i, out_pc, out_instr, occupancy, 64'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, '0);
      #3;
      tests_run++;
      if (occupancy !== 3'((i < 4) ? i : 4)) begin
        tests_failed++;
        $display("FAIL bp_occ_%0d: got %0d expected %0d", i, occupancy, (i < 4) ? i : 4);
      end
      if (i >= 4) begin
        tests_run++;
        if (imem_en !== 1'b0 || imem_addr !== 64'd16) begin
          tests_failed++;
          $display("FAIL bp_hold_%0d: got en=%b addr=%h expected en=0 addr=10", i, imem_en, imem_addr);
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, '0);
      #3;
      tests_run++;
      if (out_pc !== 64'(4 * i) || occupancy !== 3'd4 || imem_en !== 1'b1) begin
        tests_failed++;
        $display("FAIL drain_%0d: got pc=%h occ=%0d en=%b expected pc=%h occ=4 en=1",
                 i, out_pc, occupancy, imem_en, 64'(4 * i));
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 64'h100);
    #3;
    tests_run++;
    if (occupancy !== 3'd3 || imem_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_pre: got occ=%0d en=%b expected occ=3 en=0", occupancy, imem_en);
    end
    cycle(1'b1, 1'b0, '0);
    #3;
    tests_run++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 64'h100) begin
      tests_failed++;
      $display("FAIL flush_next: got occ=%0d v=%b addr=%h expected 0/0/100", occupancy, out_valid, imem_addr);
    end
    cycle(1'b1, 1'b0, '0);
    #3;
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 64'h100) begin
      tests_failed++;
      $display("FAIL flush_first: got v=%b pc=%h expected 1/100", out_valid, out_pc);
    end
  endtask

  task automatic test_align();
    cycle(1'b1, 1'b1, 64'h103);
    cycle(1'b1, 1'b0, '0);
    #3;
    tests_run++;
    if (imem_addr !== 64'h100) begin
      tests_failed++;
      $display("FAIL align_addr: got %h expected 100", imem_addr);
    end
    cycle(1'b1, 1'b0, '0);
    #3;
    tests_run++;
    if (out_pc !== 64'h100 || out_instr !== (32'h100 ^ K)) begin
      tests_failed++;
      $display("FAIL align_pc: got %h/%h expected 100/%h", out_pc, out_instr, 32'h100 ^ K);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 1'b1, 64'h200);
    cycle(1'b1, 1'b1, 64'h300);
    cycle(1'b1, 1'b0, '0);
    #3;
    tests_run++;
    if (imem_addr !== 64'h300 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_addr: got addr=%h v=%b expected 300/0", imem_addr, out_valid);
    end
    cycle(1'b1, 1'b0, '0);
    #3;
    tests_run++;
    if (out_pc !== 64'h300) begin
      tests_failed++;
      $display("FAIL b2b_pc: got %h expected 300", out_pc);
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] seq [4];
    seq[0] = 64'hFFFF_FFFF_FFFF_FFF8;
    seq[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    seq[2] = 64'h0;
    seq[3] = 64'h4;
    do_reset();
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, '0);
      #3;
      tests_run++;
      if (out_valid_w !== 1'b1 || out_pc_w !== seq[i] || out_instr_w !== (seq[i][31:0] ^ K)) begin
        tests_failed++;
        $display("FAIL wrap_%0d: got v=%b pc=%h expected 1/%h", i, out_valid_w, out_pc_w, seq[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    #3;
    tests_run++;
    if (occupancy !== 3'd2) begin
      tests_failed++;
      $display("FAIL areset_pre: got occ=%0d expected 2", occupancy);
    end
    #2;
    do_reset();
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || out_pc !== 64'h0 || out_instr !== 32'h0 || imem_addr !== 64'h0) begin
      tests_failed++;
      $display("FAIL areset: got v=%b occ=%0d pc=%h instr=%h addr=%h expected all 0",
               out_valid, occupancy, out_pc, out_instr, imem_addr);
    end
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    #3;
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== K) begin
      tests_failed++;
      $display("FAIL areset_restart: got v=%b pc=%h instr=%h expected 1/0/%h", out_valid, out_pc, out_instr, K);
    end
  endtask

  task automatic test_random();
    logic r;
    for (int i = 0; i < 200; i++) begin
      r = ($urandom_range(0, 15) == 0);
      cycle(1'($urandom_range(0, 1)), r, 64'($urandom_range(0, 65535)) << 4);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_align();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    test_random();
    cycle(1'b0, 1'b0, '0);
    #5;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
